// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage access controller: state encodings,
// datapath widths and the default timeout.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_e;

  localparam int MAX_WAIT_DEFAULT = 64;
  localparam int ADDR_W           = 16;
  localparam int DATA_W           = 16;
  localparam int CTR_W            = 8;

endpackage

// File: rtl/mem_access_wait_ctr.sv
// Wait-cycle counter for the BUSY timeout: synchronous clear, count enable.
module mem_wait_ctr
  import mem_access_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CTR_W-1:0] count
);

  logic [CTR_W-1:0] count_q;
  logic [CTR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-memory access controller: issues one aligned load/store,
// stalls the pipeline until completion, and traps on misalignment/fault/timeout.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              memRead_in,
  input  logic              memWrite_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wrData_in,
  input  logic              halt_in,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              mem_err,
  output logic [DATA_W-1:0] readData_out,
  output logic              wb_valid_out,
  output logic              stall_out,
  output logic              err_out
);

  localparam logic [CTR_W-1:0] WAIT_LAST = CTR_W'(MAX_WAIT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_q, wr_d;

  logic              access;
  logic              latch_en;
  logic              capture;
  logic              ctr_clr;
  logic              ctr_en;
  logic [CTR_W-1:0]  wait_count;

  assign access = valid_in & (memRead_in | memWrite_in) & ~halt_in;

  mem_wait_ctr u_wait_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .count (wait_count)
  );

  always_comb begin
    state_d      = state_q;
    latch_en     = 1'b0;
    capture      = 1'b0;
    ctr_clr      = 1'b0;
    ctr_en       = 1'b0;
    mem_req      = 1'b0;
    stall_out    = 1'b0;
    wb_valid_out = 1'b0;
    readData_out = '0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          stall_out = 1'b1;
          if (addr_in[0]) begin
            state_d = ERR;
          end else begin
            latch_en = 1'b1;
            ctr_clr  = 1'b1;
            state_d  = BUSY;
          end
        end else begin
          wb_valid_out = valid_in;
        end
      end
      BUSY: begin
        mem_req   = 1'b1;
        stall_out = 1'b1;
        ctr_en    = ~mem_done;
        // A fault outranks completion; completion outranks the timeout.
        if (mem_err) begin
          state_d = ERR;
        end else if (mem_done) begin
          capture = ~wr_q;
          state_d = DONE;
        end else if (wait_count == WAIT_LAST) begin
          state_d = ERR;
        end
      end
      DONE: begin
        wb_valid_out = 1'b1;
        readData_out = wr_q ? '0 : rdata_q;
        state_d      = IDLE;
      end
      ERR: begin
        stall_out = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = latch_en ? addr_in : addr_q;
    wdata_d = latch_en ? wrData_in : wdata_q;
    wr_d    = latch_en ? memWrite_in : wr_q;
    rdata_d = capture ? mem_rdata : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr    = (state_q == BUSY) & wr_q;
  assign err_out   = (state_q == ERR);

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter MAX_WAIT, default 64, max BUSY cycles allowed before timeout; legal range 1..255.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 valid_in  in  1  EX/MEM holds a live instruction.
REQ-005 memRead_in  in  1  instruction is a load.
REQ-006 memWrite_in  in  1  instruction is a store.
REQ-007 addr_in  in  16  byte address (EX/MEM ALU result).
REQ-008 wrData_in  in  16  store data.
REQ-009 halt_in  in  1  instruction is HALT.
REQ-010 mem_req  out  1  data-memory request, held until mem_done.
REQ-011 mem_wr  out  1  1 = write, 0 = read; valid while mem_req.
REQ-012 mem_addr  out  16  latched access address.
REQ-013 mem_wdata  out  16  latched store data.
REQ-014 mem_rdata  in  16  memory read data, valid with mem_done.
REQ-015 mem_done  in  1  access complete, one-cycle pulse.
REQ-016 mem_err  in  1  memory-reported fault.
REQ-017 readData_out  out  16  load data for the MEM/WB register.
REQ-018 wb_valid_out  out  1  MEM/WB captures a real instruction this cycle; 0 = bubble.
REQ-019 stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle.
REQ-020 err_out  out  1  sticky fault flag.

Function
REQ-021 FSM states: IDLE, BUSY, DONE, ERR.
- IDLE, access = valid_in & (memRead_in | memWrite_in) & ~halt_in.
- access & addr_in[0]=0: latch addr/data/direction; stall_out=1; wb_valid_out=0; next BUSY.
- access & addr_in[0]=1: next ERR.
- no access: stall_out=0; wb_valid_out=valid_in; readData_out=0.
REQ-022 BUSY: mem_req=1; stall_out=1; wb_valid_out=0; mem_addr/mem_wdata/mem_wr constant.
- mem_done & ~mem_err: capture mem_rdata (reads only); next DONE.
- mem_err: next ERR; mem_err beats mem_done in the same cycle.
REQ-023 Timeout: 8-bit wait counter cleared on BUSY entry, +1 per BUSY cycle without mem_done; counter = MAX_WAIT-1 with no mem_done -> ERR; mem_done in that same cycle wins.
REQ-024 DONE: mem_req=0; stall_out=0; wb_valid_out=1; readData_out = captured data for a load, 0 for a store; next IDLE unconditionally; no re-issue of the same instruction.
REQ-025 ERR: err_out=1; stall_out=1; wb_valid_out=0; mem_req=0; exit only by reset.
REQ-026 mem_done or mem_err outside BUSY is ignored.
REQ-027 Minimum load latency: issue cycle + 1 BUSY cycle + DONE = 3 cycles; stall_out high for the first 2.
REQ-028 HALT and non-memory instructions pass in 1 cycle with no memory request.

Reset
REQ-029 rst=0 at a clock edge: state IDLE, counter 0, latches 0, err_out 0.
REQ-030 Reset output values: mem_req 0, mem_wr 0, mem_addr 0, mem_wdata 0, readData_out 0, wb_valid_out 0, stall_out 0.
REQ-031 Reset during BUSY drops mem_req at that edge; a late mem_done is ignored.

Structure
REQ-032 The shared pipeline definitions file holds the state encodings (IDLE 2'b00, BUSY 2'b01, DONE 2'b10, ERR 2'b11) and the MAX_WAIT default.
REQ-033 The wait counter is sub-module mem_wait_ctr: 8-bit, synchronous clear, enable, count output.
REQ-034 All registers are in mem_access or mem_wait_ctr; outputs decode from state and latches only, except the IDLE-state stall_out and wb_valid_out.

Verification
REQ-035 Load addr 0x0040, mem_done 1 cycle after mem_req, mem_rdata 0xBEEF -> stall_out 1 for 2 cycles, then readData_out 0xBEEF with wb_valid_out 1.
REQ-036 Store addr 0x0010 data 0x1234, mem_done after 4 cycles -> mem_wr 1, mem_addr 0x0010, mem_wdata 0x1234 stable throughout; readData_out 0 in DONE.
REQ-037 Load addr 0x0003 -> ERR next cycle, err_out 1, mem_req never asserted, stall held until reset.
REQ-038 MAX_WAIT=4, no mem_done -> exactly 4 BUSY cycles, then err_out 1; second run with mem_done on the 4th BUSY cycle -> DONE, no error.
REQ-039 rst=0 on the 2nd BUSY cycle, mem_done 1 cycle later -> IDLE, all outputs 0, mem_done ignored.
REQ-040 Back-to-back load, ADD, HALT -> load stalls; ADD and HALT each wb_valid_out 1 with no stall and no mem_req.
